// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter
//   Round-robin write arbiter that merges NREQ pixel-write streams into a
//   single framebuffer write port. One requester owns the port per grant.
//   A grant lasts for up to BURST_LEN accepted beats, or until that
//   requester drops valid. Accepted beats appear on the write port one
//   cycle later. Beats whose address is outside the framebuffer are
//   consumed without being written, and they raise a sticky error flag.
//
// Ports
//   clk_i        single clock
//   rst_i        synchronous, active-high reset
//   en_i         global write gate; while low nothing is accepted and a grant is frozen
//   req_valid_i  per-requester write valid                        [NREQ]
//   req_ready_o  per-requester accept (combinational)             [NREQ]
//   req_addr_i   packed per-requester pixel address               [NREQ*ADDR_BITS]
//   req_data_i   packed per-requester 24-bit pixel data           [NREQ*24]
//   pxl_addr_o   framebuffer write address (registered)
//   pxl_data_o   framebuffer write data (registered)
//   pxl_en_o     framebuffer write strobe (registered)
//   grant_o      one-hot owner of the port, zero when idle
//   busy_o       high while a grant is active
//   oob_err_o    sticky flag: an out-of-range address was accepted
module fb_wr_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int PIXELS    = 921600,
  parameter  int BURST_LEN = 16,
  localparam int ADDR_BITS = $clog2(PIXELS),
  localparam int PTR_BITS  = $clog2(NREQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr_i,
  input  logic [NREQ*24-1:0]        req_data_i,
  output logic [ADDR_BITS-1:0]      pxl_addr_o,
  output logic [23:0]               pxl_data_o,
  output logic                      pxl_en_o,
  output logic [NREQ-1:0]           grant_o,
  output logic                      busy_o,
  output logic                      oob_err_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One extra bit so that PIXELS itself is representable when it is a power of two.
  localparam logic [ADDR_BITS:0] PIX_LIMIT = (ADDR_BITS+1)'(PIXELS);
  localparam logic [7:0]         LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NREQ - 1);

  // First valid requester at or above ptr, wrapping at NREQ (not at 2^PTR_BITS).
  // The loop runs downward so the smallest distance from ptr wins.
  function automatic logic [PTR_BITS-1:0] rr_pick(input logic [NREQ-1:0]     valid,
                                                  input logic [PTR_BITS-1:0] ptr);
    int idx;
    rr_pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (valid[idx]) rr_pick = PTR_BITS'(idx);
    end
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] a);
    return ({1'b0, a} < PIX_LIMIT);
  endfunction

  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + PTR_BITS'(1);
  endfunction

  state_t                 state_q,    state_d;
  logic [PTR_BITS-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [PTR_BITS-1:0]    gnt_idx_q,  gnt_idx_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   pxl_en_q,   pxl_en_d;
  logic [ADDR_BITS-1:0]   pxl_addr_q, pxl_addr_d;
  logic [23:0]            pxl_data_q, pxl_data_d;
  logic                   oob_err_q,  oob_err_d;

  logic [NREQ-1:0]        grant_vec;
  logic                   sel_valid;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [23:0]            sel_data;
  logic                   active;
  logic                   xfer;

  // Requester currently owning the port (valid/addr/data mux).
  always_comb begin
    grant_vec = '0;
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_q == PTR_BITS'(i)) begin
        grant_vec[i] = 1'b1;
        sel_valid    = req_valid_i[i];
        sel_addr     = req_addr_i[i*ADDR_BITS +: ADDR_BITS];
        sel_data     = req_data_i[i*24 +: 24];
      end
    end
  end

  // Reset masks the handshake outputs in the same cycle, so a beat offered
  // while rst_i is high is never accepted.
  assign active      = (state_q == ST_GRANT) && !rst_i;
  assign busy_o      = active;
  assign grant_o     = active ? grant_vec : '0;
  assign req_ready_o = (active && en_i) ? grant_vec : '0;
  assign xfer        = active && en_i && sel_valid;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    pxl_en_d   = 1'b0;
    pxl_addr_d = pxl_addr_q;
    pxl_data_d = pxl_data_q;
    oob_err_d  = oob_err_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i && (|req_valid_i)) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = rr_pick(req_valid_i, rr_ptr_q);
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // With en_i low the grant is frozen: no beat, no release.
        if (en_i) begin
          if (!sel_valid || (beat_cnt_q == LAST_BEAT)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = next_ptr(gnt_idx_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range beats are consumed but never reach the framebuffer.
    if (xfer) begin
      if (addr_in_range(sel_addr)) begin
        pxl_en_d   = 1'b1;
        pxl_addr_d = sel_addr;
        pxl_data_d = sel_data;
      end else begin
        oob_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
      pxl_en_q   <= 1'b0;
      pxl_addr_q <= '0;
      pxl_data_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
      pxl_en_q   <= pxl_en_d;
      pxl_addr_q <= pxl_addr_d;
      pxl_data_q <= pxl_data_d;
      oob_err_q  <= oob_err_d;
    end
  end

  assign pxl_en_o   = pxl_en_q;
  assign pxl_addr_o = pxl_addr_q;
  assign pxl_data_o = pxl_data_q;
  assign oob_err_o  = oob_err_q;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Bench for fb_wr_arbiter: a vector table for short single-cycle behaviour,
// directed multi-cycle sequences, and a randomized run, all checked against
// a transaction-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_fb_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int PIXELS    = 921600;
  localparam int BURST_LEN = 16;
  localparam int AB        = $clog2(PIXELS);

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*AB-1:0]   req_addr_i;
  logic [NREQ*24-1:0]   req_data_i;
  logic [AB-1:0]        pxl_addr_o;
  logic [23:0]          pxl_data_o;
  logic                 pxl_en_o;
  logic [NREQ-1:0]      grant_o;
  logic                 busy_o;
  logic                 oob_err_o;

  fb_wr_arbiter #(.NREQ(NREQ), .PIXELS(PIXELS), .BURST_LEN(BURST_LEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .pxl_addr_o(pxl_addr_o), .pxl_data_o(pxl_data_o), .pxl_en_o(pxl_en_o),
    .grant_o(grant_o), .busy_o(busy_o), .oob_err_o(oob_err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- requester lanes driven by the bench ----------------
  int  lane_left [NREQ];
  int  lane_addr [NREQ];
  bit  rand_addr;
  bit  rst_r, en_r;

  function automatic logic [23:0] lane_data(input int i);
    return 24'((lane_addr[i] * 7) ^ (i << 20));
  endfunction

  function automatic int pick_addr();
    if ($urandom % 8 == 0) return PIXELS + int'($urandom_range(0, 1000));
    return int'($urandom_range(0, PIXELS - 1));
  endfunction

  // ---------------- reference model ----------------
  bit m_busy;
  int m_gnt, m_beats, m_ptr;
  bit m_pen, m_oob;
  int m_paddr, m_pdata;

  task automatic model_step();
    bit xf;
    int sa;
    m_pen = 1'b0;
    if (rst_r) begin
      m_busy = 0; m_gnt = 0; m_beats = 0; m_ptr = 0;
      m_paddr = 0; m_pdata = 0; m_oob = 0;
      return;
    end
    xf = m_busy && en_r && req_valid_i[m_gnt];
    if (xf) begin
      sa = lane_addr[m_gnt];
      if (sa < PIXELS) begin
        m_pen = 1'b1; m_paddr = sa; m_pdata = int'(lane_data(m_gnt));
      end else begin
        m_oob = 1'b1;
      end
    end
    if (!m_busy) begin
      if (en_r && (|req_valid_i)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid_i[(m_ptr + k) % NREQ]) begin
            m_gnt = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_busy = 1; m_beats = 0;
      end
    end else if (en_r) begin
      if (xf) m_beats++;
      if (!xf || m_beats == BURST_LEN) begin
        m_busy = 0; m_ptr = (m_gnt + 1) % NREQ; m_beats = 0;
      end
    end
  endtask

  // ---------------- logs ----------------
  int wr_addr[$];
  int wr_cyc[$];
  int gnt_seq[$];
  int gnt_cyc[$];
  int cyc = 0;
  bit seen_busy = 0;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_cyc.delete(); gnt_seq.delete(); gnt_cyc.delete();
  endtask

  // One clock: drive at negedge, check combinational outputs, clock, check registers.
  task automatic cycle();
    logic [NREQ-1:0] exp_gnt, exp_rdy, acc;
    rst_i = rst_r;
    en_i  = en_r;
    for (int i = 0; i < NREQ; i++) begin
      req_valid_i[i]          = (lane_left[i] > 0);
      req_addr_i[i*AB +: AB]  = AB'(lane_addr[i]);
      req_data_i[i*24 +: 24]  = lane_data(i);
    end
    #1;
    exp_gnt = (!rst_r && m_busy) ? (NREQ'(1) << m_gnt) : '0;
    exp_rdy = en_r ? exp_gnt : '0;
    chk("grant", 32'(grant_o), 32'(exp_gnt));
    chk("ready", 32'(req_ready_o), 32'(exp_rdy));
    chk("busy", 32'(busy_o), 32'(!rst_r && m_busy));
    if ((|grant_o) && !seen_busy) begin
      gnt_seq.push_back(onehot_idx(grant_o));
      gnt_cyc.push_back(cyc);
    end
    seen_busy = |grant_o;
    acc = exp_rdy & req_valid_i;
    @(posedge clk);
    model_step();
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        lane_left[i]--;
        if (rand_addr) lane_addr[i] = pick_addr();
        else lane_addr[i] = (lane_addr[i] >= PIXELS) ? 40 : lane_addr[i] + 1;
      end
    end
    #1;
    cyc++;
    chk("pxl_en", 32'(pxl_en_o), 32'(m_pen));
    chk("pxl_addr", 32'(pxl_addr_o), 32'(m_paddr));
    chk("pxl_data", 32'(pxl_data_o), 32'(m_pdata));
    chk("oob_err", 32'(oob_err_o), 32'(m_oob));
    if (pxl_en_o) begin
      wr_addr.push_back(int'(pxl_addr_o));
      wr_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin lane_left[i] = 0; lane_addr[i] = 0; end
    rst_r = 1; en_r = 0;
    cycle();
    rst_r = 0; en_r = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] v;
    int         addr;
    logic [3:0] e_rdy;
    logic [3:0] e_gnt;
    bit         e_busy;
    bit         e_pen;
    int         e_paddr;
    int         e_pdata;
    bit         e_oob;
  } vec_t;

  task automatic apply_vec(input vec_t r, input int row);
    rst_i = r.rst; en_i = r.en; req_valid_i = r.v;
    for (int i = 0; i < NREQ; i++) begin
      lane_addr[i]           = r.addr;
      req_addr_i[i*AB +: AB] = AB'(r.addr);
      req_data_i[i*24 +: 24] = lane_data(i);
    end
    #1;
    chk($sformatf("tbl%0d_ready", row), 32'(req_ready_o), 32'(r.e_rdy));
    chk($sformatf("tbl%0d_grant", row), 32'(grant_o), 32'(r.e_gnt));
    chk($sformatf("tbl%0d_busy", row), 32'(busy_o), 32'(r.e_busy));
    @(posedge clk);
    #1;
    chk($sformatf("tbl%0d_pen", row), 32'(pxl_en_o), 32'(r.e_pen));
    chk($sformatf("tbl%0d_paddr", row), 32'(pxl_addr_o), 32'(r.e_paddr));
    chk($sformatf("tbl%0d_pdata", row), 32'(pxl_data_o), 32'(r.e_pdata));
    chk($sformatf("tbl%0d_oob", row), 32'(oob_err_o), 32'(r.e_oob));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required to end before 1 ms");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    tbl[0]  = '{1, 0, 4'h0, 0,      4'h0, 4'h0, 0, 0, 0,  0,         0};
    tbl[1]  = '{0, 1, 4'h1, 5,      4'h0, 4'h0, 0, 0, 0,  0,         0};
    tbl[2]  = '{0, 1, 4'h1, 5,      4'h1, 4'h1, 1, 1, 5,  'h23,      0};
    tbl[3]  = '{0, 0, 4'h1, 6,      4'h0, 4'h1, 1, 0, 5,  'h23,      0};
    tbl[4]  = '{0, 1, 4'h1, 7,      4'h1, 4'h1, 1, 1, 7,  'h31,      0};
    tbl[5]  = '{0, 1, 4'h1, PIXELS, 4'h1, 4'h1, 1, 0, 7,  'h31,      1};
    tbl[6]  = '{0, 1, 4'h4, 9,      4'h1, 4'h1, 1, 0, 7,  'h31,      1};
    tbl[7]  = '{0, 1, 4'h5, 9,      4'h0, 4'h0, 0, 0, 7,  'h31,      1};
    tbl[8]  = '{0, 1, 4'h5, 10,     4'h4, 4'h4, 1, 1, 10, 'h200046,  1};
    tbl[9]  = '{1, 1, 4'h5, 11,     4'h0, 4'h0, 0, 0, 0,  0,         0};
    tbl[10] = '{0, 1, 4'h5, 12,     4'h0, 4'h0, 0, 0, 0,  0,         0};
    tbl[11] = '{0, 1, 4'h5, 13,     4'h1, 4'h1, 1, 1, 13, 'h5B,      0};
    tbl[12] = '{0, 0, 4'h0, 13,     4'h0, 4'h1, 1, 0, 13, 'h5B,      0};
    tbl[13] = '{0, 1, 4'h0, 13,     4'h1, 4'h1, 1, 0, 13, 'h5B,      0};
    tbl[14] = '{0, 1, 4'h0, 13,     4'h0, 4'h0, 0, 0, 13, 'h5B,      0};

    rst_i = 1; en_i = 0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
    rand_addr = 0; rst_r = 1; en_r = 0;
    m_busy = 0; m_gnt = 0; m_beats = 0; m_ptr = 0; m_pen = 0; m_oob = 0; m_paddr = 0; m_pdata = 0;
    for (int i = 0; i < NREQ; i++) begin lane_left[i] = 0; lane_addr[i] = 0; end
    @(negedge clk);

    for (int r = 0; r < 15; r++) apply_vec(tbl[r], r);

    // Single requester, 20 beats: 16-beat burst, one idle cycle, then the rest.
    do_reset(); clear_logs();
    lane_left[0] = 20; lane_addr[0] = 0;
    run(40);
    chk("single_wr_count", 32'(wr_addr.size()), 32'd20);
    if (wr_addr.size() == 20) begin
      for (int k = 0; k < 20; k++) chk($sformatf("single_wr_addr%0d", k), 32'(wr_addr[k]), 32'(k));
      chk("single_burst_span", 32'(wr_cyc[15] - wr_cyc[0]), 32'd15);
      chk("single_regrant_gap", 32'(wr_cyc[16] - wr_cyc[15]), 32'd2);
    end
    chk("single_grant_count", 32'(gnt_seq.size()), 32'd2);
    if (gnt_seq.size() == 2) chk("single_regrant_idx", 32'(gnt_seq[1]), 32'd0);

    // All four requesters valid continuously.
    do_reset(); clear_logs();
    for (int i = 0; i < NREQ; i++) begin lane_left[i] = 1000; lane_addr[i] = i * 1000; end
    run(85);
    chk("rr_grant_count", 32'(gnt_seq.size()), 32'd5);
    if (gnt_seq.size() == 5) begin
      chk("rr_order0", 32'(gnt_seq[0]), 32'd0);
      chk("rr_order1", 32'(gnt_seq[1]), 32'd1);
      chk("rr_order2", 32'(gnt_seq[2]), 32'd2);
      chk("rr_order3", 32'(gnt_seq[3]), 32'd3);
      chk("rr_order4", 32'(gnt_seq[4]), 32'd0);
    end
    chk("rr_wr_count", 32'(wr_addr.size()), 32'd80);
    if (wr_addr.size() == 80) begin
      chk("rr_wr16", 32'(wr_addr[16]), 32'd1000);
      chk("rr_wr63", 32'(wr_addr[63]), 32'd3015);
      chk("rr_wr79", 32'(wr_addr[79]), 32'd31);
    end

    // Early release: req 2 stops after 3 beats, req 3 waiting.
    do_reset(); clear_logs();
    lane_left[2] = 3;  lane_addr[2] = 200;
    lane_left[3] = 10; lane_addr[3] = 300;
    run(20);
    chk("early_grants", 32'(gnt_seq.size()), 32'd2);
    if (gnt_seq.size() == 2) begin
      chk("early_first", 32'(gnt_seq[0]), 32'd2);
      chk("early_second", 32'(gnt_seq[1]), 32'd3);
      chk("early_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd5);
    end
    chk("early_wr_count", 32'(wr_addr.size()), 32'd13);

    // en_i low for 5 cycles mid-burst.
    do_reset(); clear_logs();
    lane_left[1] = 10; lane_addr[1] = 500;
    run(4);
    chk("gate_pre_writes", 32'(wr_addr.size()), 32'd3);
    en_r = 0;
    run(5);
    chk("gate_no_writes", 32'(wr_addr.size()), 32'd3);
    en_r = 1;
    run(12);
    chk("gate_total_writes", 32'(wr_addr.size()), 32'd10);
    if (wr_addr.size() == 10) chk("gate_resume_addr", 32'(wr_addr[3]), 32'd503);
    chk("gate_one_grant", 32'(gnt_seq.size()), 32'd1);

    // Out-of-range address followed by an in-range beat.
    do_reset(); clear_logs();
    lane_left[0] = 3; lane_addr[0] = PIXELS;
    run(6);
    chk("oob_wr_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) chk("oob_next_addr", 32'(wr_addr[0]), 32'd40);
    chk("oob_sticky", 32'(oob_err_o), 32'd1);

    // Reset in the middle of a burst on req 1; next grant starts from req 0.
    do_reset(); clear_logs();
    lane_left[1] = 20; lane_addr[1] = 600;
    for (int c = 0; c < 30 && lane_left[1] > 13; c++) cycle();
    chk("rstmid_reach_beat7", 32'(lane_left[1]), 32'd13);
    lane_left[0] = 4; lane_addr[0] = 700;
    rst_r = 1;
    cycle();
    rst_r = 0;
    chk("rstmid_pen", 32'(pxl_en_o), 32'd0);
    chk("rstmid_addr", 32'(pxl_addr_o), 32'd0);
    chk("rstmid_left1", 32'(lane_left[1]), 32'd13);
    clear_logs();
    run(8);
    chk("rstmid_grants", 32'(gnt_seq.size() > 0), 32'd1);
    if (gnt_seq.size() > 0) chk("rstmid_next_grant", 32'(gnt_seq[0]), 32'd0);

    // Randomized traffic against the model.
    do_reset(); clear_logs();
    rand_addr = 1;
    for (int c = 0; c < 1500; c++) begin
      en_r  = ($urandom % 8) != 0;
      rst_r = ($urandom % 300) == 0;
      for (int i = 0; i < NREQ; i++) begin
        if (lane_left[i] == 0 && ($urandom % 4) == 0) begin
          lane_left[i] = int'($urandom_range(1, 40));
          lane_addr[i] = pick_addr();
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
